// File: rtl/ysyx_220066_trap_ctrl.sv
// Trap/return sequencer between commit and the machine-mode CSR unit:
// selects one event, flushes and drains the pipe, strobes the CSR unit, then redirects fetch.
module ysyx_220066_trap_ctrl #(
    parameter int unsigned DRAIN_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [63:0] commit_pc,
    input  logic        exc_ebreak,
    input  logic        exc_illegal,
    input  logic        exc_ecall,
    input  logic        exc_ld_misalign,
    input  logic        exc_st_misalign,
    input  logic        is_mret,
    input  logic        timer_irq,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        pipe_empty,
    input  logic [63:0] csr_nxtpc,
    input  logic        redirect_ready,
    output logic        stall,
    output logic        flush,
    output logic        raise_intr,
    output logic        ret,
    output logic [63:0] intr_no,
    output logic [63:0] intr_pc,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        drain_err,
    output logic [31:0] trap_cnt
);

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [XLEN-1:0] CAUSE_TIMER   = 64'h8000_0000_0000_0007;
    localparam logic [XLEN-1:0] CAUSE_EBREAK  = 64'd3;
    localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 64'd2;
    localparam logic [XLEN-1:0] CAUSE_ECALL   = 64'd11;
    localparam logic [XLEN-1:0] CAUSE_LD_MIS  = 64'd4;
    localparam logic [XLEN-1:0] CAUSE_ST_MIS  = 64'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_DRAIN,
        S_COMMIT,
        S_REDIRECT
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  drain_cnt;
    logic              kind_ret;
    logic              irq_pend, any_exc, accept, drain_timeout, handshake;
    logic [XLEN-1:0]   sel_cause;
    logic              sel_ret;
    logic              flush_d, raise_intr_d, ret_d, redirect_valid_d;

    assign irq_pend      = timer_irq & mstatus_mie & mie_mtie;
    assign any_exc       = exc_ebreak | exc_illegal | exc_ecall | exc_ld_misalign | exc_st_misalign;
    assign accept        = (state == S_IDLE) & commit_valid & (irq_pend | any_exc | is_mret);
    assign stall         = accept | (state != S_IDLE);
    assign drain_timeout = (drain_cnt == CNT_W'(DRAIN_MAX - 1));
    assign handshake     = redirect_valid & redirect_ready;

    // Fixed-priority event selection; an interrupt squashes anything committing with it
    always_comb begin
        sel_cause = '0;
        sel_ret   = 1'b0;
        if (irq_pend)             sel_cause = CAUSE_TIMER;
        else if (exc_ebreak)      sel_cause = CAUSE_EBREAK;
        else if (exc_illegal)     sel_cause = CAUSE_ILLEGAL;
        else if (exc_ecall)       sel_cause = CAUSE_ECALL;
        else if (exc_ld_misalign) sel_cause = CAUSE_LD_MIS;
        else if (exc_st_misalign) sel_cause = CAUSE_ST_MIS;
        else if (is_mret)         sel_ret   = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (accept) state_nxt = S_FLUSH;
            S_FLUSH:    state_nxt = S_DRAIN;
            S_DRAIN:    if (pipe_empty || drain_timeout) state_nxt = S_COMMIT;
            S_COMMIT:   state_nxt = S_REDIRECT;
            S_REDIRECT: if (handshake) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered, so they are derived from the state being entered
    always_comb begin
        flush_d          = (state_nxt == S_FLUSH);
        raise_intr_d     = (state_nxt == S_COMMIT) & ~kind_ret;
        ret_d            = (state_nxt == S_COMMIT) & kind_ret;
        redirect_valid_d = (state_nxt == S_REDIRECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush          <= 1'b0;
            raise_intr     <= 1'b0;
            ret            <= 1'b0;
            redirect_valid <= 1'b0;
            intr_no        <= '0;
            intr_pc        <= '0;
            kind_ret       <= 1'b0;
            redirect_pc    <= '0;
            drain_cnt      <= '0;
            drain_err      <= 1'b0;
            trap_cnt       <= '0;
        end else begin
            flush          <= flush_d;
            raise_intr     <= raise_intr_d;
            ret            <= ret_d;
            redirect_valid <= redirect_valid_d;
            if (accept) begin
                intr_no  <= sel_cause;
                intr_pc  <= commit_pc;
                kind_ret <= sel_ret;
            end
            if (state == S_FLUSH)      drain_cnt <= '0;
            else if (state == S_DRAIN) drain_cnt <= drain_cnt + CNT_W'(1);
            if (state == S_DRAIN && !pipe_empty && drain_timeout) drain_err <= 1'b1;
            if (state == S_COMMIT) redirect_pc <= csr_nxtpc;
            if (state == S_REDIRECT && handshake) trap_cnt <= trap_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_220066_trap_ctrl.sv
// Bench for ysyx_220066_trap_ctrl: directed vector table, randomized sequences checked
// against a per-cycle timeline model, and an asynchronous reset mid-drain.
module tb_ysyx_220066_trap_ctrl;

    localparam int unsigned DMAX = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic        exc_ebreak, exc_illegal, exc_ecall, exc_ld_misalign, exc_st_misalign;
    logic        is_mret, timer_irq, mstatus_mie, mie_mtie, pipe_empty;
    logic [63:0] csr_nxtpc;
    logic        redirect_ready;
    logic        stall, flush, raise_intr, ret, redirect_valid, drain_err;
    logic [63:0] intr_no, intr_pc, redirect_pc;
    logic [31:0] trap_cnt;

    ysyx_220066_trap_ctrl #(.DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rst(rst),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .exc_ebreak(exc_ebreak), .exc_illegal(exc_illegal), .exc_ecall(exc_ecall),
        .exc_ld_misalign(exc_ld_misalign), .exc_st_misalign(exc_st_misalign),
        .is_mret(is_mret), .timer_irq(timer_irq), .mstatus_mie(mstatus_mie),
        .mie_mtie(mie_mtie), .pipe_empty(pipe_empty), .csr_nxtpc(csr_nxtpc),
        .redirect_ready(redirect_ready),
        .stall(stall), .flush(flush), .raise_intr(raise_intr), .ret(ret),
        .intr_no(intr_no), .intr_pc(intr_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .drain_err(drain_err), .trap_cnt(trap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          irq, mie, mtie;
        bit          ebreak, illegal, ecall, ld, st, mret;
        logic [63:0] pc, nxtpc;
        int          d;      // DRAIN cycles with pipe_empty low
        int          r;      // REDIRECT cycles with redirect_ready low
        logic [63:0] cause;
        bit          trap;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    bit          exp_err = 1'b0;
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference: trap cause by priority; returns trap=0 for a plain mret
    function automatic void ref_cause(input vec_t v, output logic [63:0] cause, output bit trap);
        trap = 1'b1;
        if (v.irq && v.mie && v.mtie) cause = 64'h8000_0000_0000_0007;
        else if (v.ebreak)            cause = 3;
        else if (v.illegal)           cause = 2;
        else if (v.ecall)             cause = 11;
        else if (v.ld)                cause = 4;
        else if (v.st)                cause = 6;
        else begin cause = 0; trap = 1'b0; end
    endfunction

    function automatic vec_t mk(input bit irq, mie, mtie, ebreak, illegal, ecall, ld, st, mret,
                                input logic [63:0] pc, nxtpc, input int d, r,
                                input logic [63:0] cause, input bit trap);
        vec_t v;
        v.irq = irq; v.mie = mie; v.mtie = mtie; v.ebreak = ebreak; v.illegal = illegal;
        v.ecall = ecall; v.ld = ld; v.st = st; v.mret = mret; v.pc = pc; v.nxtpc = nxtpc;
        v.d = d; v.r = r; v.cause = cause; v.trap = trap;
        return v;
    endfunction

    task automatic drive_garbage();
        commit_valid = 1'($urandom); commit_pc = rnd64();
        exc_ebreak = 1'($urandom); exc_illegal = 1'($urandom); exc_ecall = 1'($urandom);
        exc_ld_misalign = 1'($urandom); exc_st_misalign = 1'($urandom); is_mret = 1'($urandom);
        timer_irq = 1'($urandom); mstatus_mie = 1'($urandom); mie_mtie = 1'($urandom);
    endtask

    // One IDLE cycle whose inputs must not start a sequence
    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_flush", 64'(flush), 64'd0);
        chk("idle_strobe", 64'(raise_intr | ret), 64'd0);
        chk("idle_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("idle_trap_cnt", 64'(trap_cnt), 64'(exp_cnt));
        drive_garbage();
        pipe_empty = 1'($urandom); redirect_ready = 1'($urandom); csr_nxtpc = rnd64();
        if (commit_valid) begin
            exc_ebreak = 0; exc_illegal = 0; exc_ecall = 0;
            exc_ld_misalign = 0; exc_st_misalign = 0; is_mret = 0;
            if (timer_irq && mstatus_mie) mie_mtie = 0;
        end
        #1 chk("idle_stall", 64'(stall), 64'd0);
    endtask

    // Full sequence; t counts cycles from the accepting cycle (t=0)
    task automatic run_seq(input vec_t v);
        int  dd, tc, tend;
        bit  to;
        dd   = (v.d < int'(DMAX)) ? v.d : int'(DMAX) - 1;
        to   = (v.d >= int'(DMAX));
        tc   = 3 + dd;
        tend = tc + 1 + v.r;
        for (int t = 0; t <= tend; t++) begin
            @(negedge clk);
            chk("flush", 64'(flush), 64'(t == 1));
            chk("raise_intr", 64'(raise_intr), 64'(t == tc && v.trap));
            chk("ret", 64'(ret), 64'(t == tc && !v.trap));
            chk("redirect_valid", 64'(redirect_valid), 64'(t > tc));
            if (t >= 1) begin
                chk("intr_no", intr_no, v.cause);
                chk("intr_pc", intr_pc, v.pc);
            end
            if (t > tc) chk("redirect_pc", redirect_pc, v.nxtpc);
            chk("drain_err", 64'(drain_err), 64'(exp_err || (to && t >= tc)));
            chk("trap_cnt", 64'(trap_cnt), 64'(exp_cnt));
            if (t == 0) begin
                commit_valid = 1; commit_pc = v.pc;
                exc_ebreak = v.ebreak; exc_illegal = v.illegal; exc_ecall = v.ecall;
                exc_ld_misalign = v.ld; exc_st_misalign = v.st; is_mret = v.mret;
                timer_irq = v.irq; mstatus_mie = v.mie; mie_mtie = v.mtie;
            end else begin
                drive_garbage();
            end
            pipe_empty     = (t >= 2) ? (t >= 2 + v.d) : 1'($urandom);
            csr_nxtpc      = (t == tc) ? v.nxtpc : rnd64();
            redirect_ready = (t > tc) ? (t >= tc + 1 + v.r) : 1'($urandom);
            #1 chk("stall", 64'(stall), 64'd1);
        end
        exp_cnt++;
        if (to) exp_err = 1'b1;
    endtask

    initial begin
        vec_t v;
        rst = 1;
        commit_valid = 0; commit_pc = 0; exc_ebreak = 0; exc_illegal = 0; exc_ecall = 0;
        exc_ld_misalign = 0; exc_st_misalign = 0; is_mret = 0; timer_irq = 0;
        mstatus_mie = 0; mie_mtie = 0; pipe_empty = 1; csr_nxtpc = 0; redirect_ready = 1;

        //        irq mie mtie eb il ec ld st mr pc                     nxtpc                  d         r  cause                   trap
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,0, 64'h8000_0010, 64'h8000_1000, 0,        0, 64'd11,                 1));
        tbl.push_back(mk(1,1,1, 0,1,0,0,0,0, 64'h8000_0020, 64'h8000_1000, 0,        0, 64'h8000_0000_0000_0007, 1));
        tbl.push_back(mk(1,1,0, 0,1,0,0,0,0, 64'h8000_0024, 64'h8000_1000, 1,        0, 64'd2,                  1));
        tbl.push_back(mk(0,1,1, 0,0,0,0,0,1, 64'h8000_0030, 64'h8000_0044, 0,        0, 64'd0,                  0));
        tbl.push_back(mk(0,0,0, 1,0,1,0,0,0, 64'h8000_0034, 64'h8000_2000, 2,        1, 64'd3,                  1));
        tbl.push_back(mk(0,0,0, 0,0,0,1,1,0, 64'h8000_0038, 64'h8000_2004, 0,        2, 64'd4,                  1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,1,1, 64'h8000_003c, 64'h8000_2008, 0,        0, 64'd6,                  1));
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,1, 64'h8000_0040, 64'h8000_200c, 0,        0, 64'd11,                 1));
        tbl.push_back(mk(1,1,1, 0,0,0,0,0,1, 64'h8000_0048, 64'h8000_2010, 0,        0, 64'h8000_0000_0000_0007, 1));
        tbl.push_back(mk(0,0,0, 0,1,0,0,0,0, 64'h8000_004c, 64'h8000_2014, DMAX-1,   0, 64'd2,                  1));
        tbl.push_back(mk(0,0,0, 0,0,1,0,0,0, 64'h8000_0050, 64'h8000_2018, 0,        5, 64'd11,                 1));
        tbl.push_back(mk(0,0,0, 0,0,0,1,0,0, 64'h8000_0054, 64'h8000_201c, DMAX+5,   0, 64'd4,                  1));
        tbl.push_back(mk(0,0,0, 0,0,0,0,0,1, 64'h8000_0058, 64'h8000_0060, 1,        1, 64'd0,                  0));

        #2;
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_intr_no", intr_no, 64'd0);
        chk("rst_redirect_pc", redirect_pc, 64'd0);
        chk("rst_trap_cnt", 64'(trap_cnt), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // Back-to-back sequences: each starts the cycle after the previous handshake
        foreach (tbl[i]) run_seq(tbl[i]);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            int gaps;
            gaps = int'($urandom_range(0, 3));
            for (int g = 0; g < gaps; g++) idle_cycle();
            do begin
                v.irq = 1'($urandom); v.mie = 1'($urandom); v.mtie = 1'($urandom);
                v.ebreak = ($urandom_range(0, 5) == 0); v.illegal = ($urandom_range(0, 5) == 0);
                v.ecall = ($urandom_range(0, 5) == 0); v.ld = ($urandom_range(0, 5) == 0);
                v.st = ($urandom_range(0, 5) == 0); v.mret = ($urandom_range(0, 3) == 0);
            end while (!((v.irq && v.mie && v.mtie) || v.ebreak || v.illegal || v.ecall ||
                         v.ld || v.st || v.mret));
            v.pc = rnd64(); v.nxtpc = rnd64();
            v.d = ($urandom_range(0, 7) == 0) ? int'(DMAX) + int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, 4));
            v.r = int'($urandom_range(0, 3));
            ref_cause(v, v.cause, v.trap);
            run_seq(v);
        end

        // Asynchronous reset while stuck in DRAIN
        @(negedge clk);
        commit_valid = 1; commit_pc = 64'h8000_0100; exc_ecall = 1; exc_ebreak = 0;
        exc_illegal = 0; exc_ld_misalign = 0; exc_st_misalign = 0; is_mret = 0; timer_irq = 0;
        pipe_empty = 0;
        @(negedge clk); commit_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_stall", 64'(stall), 64'd1);
        chk("drain_err_sticky", 64'(drain_err), 64'd1);
        #2 rst = 1;
        #1;
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_flush", 64'(flush), 64'd0);
        chk("arst_redirect_valid", 64'(redirect_valid), 64'd0);
        chk("arst_intr_no", intr_no, 64'd0);
        chk("arst_intr_pc", intr_pc, 64'd0);
        chk("arst_redirect_pc", redirect_pc, 64'd0);
        chk("arst_drain_err", 64'(drain_err), 64'd0);
        chk("arst_trap_cnt", 64'(trap_cnt), 64'd0);
        exp_cnt = 0; exp_err = 0;
        @(negedge clk);
        rst = 0; pipe_empty = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst_strobe", 64'(raise_intr | ret | flush | redirect_valid), 64'd0);
            chk("post_rst_stall", 64'(stall), 64'd0);
        end
        run_seq(tbl[0]);
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_trap_ctrl.md
# ysyx_220066_trap_ctrl

Trap/return sequencer that sits between the commit stage and the machine-mode CSR unit. It picks one event per trap from exception flags, `mret`, and a gated timer interrupt. It then stalls and flushes the pipeline, waits for drain, and fires a one-cycle `raise_intr`/`ret` into the CSR unit. Finally it hands the CSR-provided target PC to the fetch stage with a valid/ready handshake.

## Interface
- DRAIN_MAX, 64, maximum cycles spent in DRAIN before forced progress (power of two, ≤256)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- commit_valid  in  1  commit stage holds a valid instruction this cycle
- commit_pc  in  64  PC of that instruction
- exc_ebreak, exc_illegal, exc_ecall, exc_ld_misalign, exc_st_misalign  in  1 each  exception flags, qualified by commit_valid
- is_mret  in  1  committing instruction is `mret`
- timer_irq  in  1  level timer interrupt line
- mstatus_mie, mie_mtie  in  1 each  enable bits from the CSR file
- pipe_empty  in  1  all stages upstream of commit are empty
- csr_nxtpc  in  64  CSR unit's target-PC output
- redirect_ready  in  1  fetch accepts the redirect
- stall  out  1  hold commit and fetch, and block CSR instruction writes
- flush  out  1  one-cycle squash of all in-flight instructions
- raise_intr  out  1  one-cycle trap strobe to the CSR unit
- ret  out  1  one-cycle return strobe to the CSR unit
- intr_no  out  64  cause value, driven to the CSR unit's NO input
- intr_pc  out  64  faulting/interrupted PC, driven to the CSR unit's pc input
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  64  new fetch PC
- drain_err  out  1  sticky: a DRAIN timed out
- trap_cnt  out  32  number of completed trap/return sequences, wraps

## Operation
- States: IDLE, FLUSH, DRAIN, COMMIT, REDIRECT.
- irq_pend = timer_irq & mstatus_mie & mie_mtie.
- accept = IDLE & commit_valid & (irq_pend | any exc_* | is_mret).
- Selection on accept uses fixed priority, highest first:
  - irq_pend: cause 64'h8000_0000_0000_0007
  - exc_ebreak: 3
  - exc_illegal: 2
  - exc_ecall: 11
  - exc_ld_misalign: 4
  - exc_st_misalign: 6
  - is_mret: return
- The selected instruction never retires. An interrupt squashes a simultaneous exception or mret, and that instruction re-executes after the handler.
- On accept: latch the cause into intr_no, commit_pc into intr_pc, and a kind bit (trap or return). Next state is FLUSH.
- FLUSH: flush=1 for exactly one cycle, then go to DRAIN and clear the drain counter.
- DRAIN: wait for pipe_empty sampled high, then go to COMMIT. If the counter reaches DRAIN_MAX-1 without pipe_empty, set drain_err and go to COMMIT anyway.
- COMMIT: drive raise_intr=1 (trap) or ret=1 (return) for one cycle. Capture csr_nxtpc into redirect_pc at the closing edge. The CSR unit supplies mtvec for a trap and the pre-update mepc for a return. Go to REDIRECT.
- REDIRECT: redirect_valid=1, with redirect_pc stable. When redirect_valid & redirect_ready: increment trap_cnt (mod 2^32) and go to IDLE.
- stall = accept | (state != IDLE). Combinational, so the accepting cycle is already stalled and the commit stage must not retire.
- intr_no and intr_pc hold their latched values outside COMMIT. The CSR unit samples them only under its strobes.
- Inputs other than pipe_empty, csr_nxtpc and redirect_ready are ignored outside IDLE. A new timer edge during a sequence is taken on the next IDLE cycle with commit_valid.

## Timing
- Reset (async, any state) sets:
  - state IDLE
  - flush, raise_intr, ret, redirect_valid = 0
  - intr_no, intr_pc, redirect_pc = 0
  - drain_err = 0, trap_cnt = 0
  - stall then follows accept combinationally.
- A reset during DRAIN or REDIRECT abandons the sequence. No strobe is emitted after reset release without a new accept.
- Minimum latency: accept in cycle 0, flush in cycle 1, DRAIN in cycle 2 (pipe_empty=1), raise_intr/ret in cycle 3, redirect_valid from cycle 4.
- The earliest next accept is the cycle after the redirect handshake.
- raise_intr and ret are never high together, and never high for more than one cycle per sequence.
- Outputs are registered except stall.

## Test plan
- ecall at commit_pc=0x8000_0010, pipe_empty=1, csr_nxtpc=0x8000_1000, redirect_ready=1 → flush in cycle 1; raise_intr in cycle 3 with intr_no=11 and intr_pc=0x8000_0010; redirect_valid with redirect_pc=0x8000_1000 in cycle 4; trap_cnt=1.
- irq_pend plus exc_illegal in the same cycle → intr_no=0x8000_0000_0000_0007. Repeat with mie_mtie=0 → intr_no=2.
- mret with csr_nxtpc=0x8000_0044 → ret pulses once, raise_intr stays 0, redirect_pc=0x8000_0044.
- pipe_empty held 0 → COMMIT entered after DRAIN_MAX cycles in DRAIN, and drain_err=1 persists until rst.
- redirect_ready held 0 for 5 cycles → redirect_valid and redirect_pc stay stable, stall=1 throughout, trap_cnt increments only at the handshake.
- rst asserted asynchronously mid-DRAIN → all outputs go to reset values immediately, and no raise_intr appears after release.
